// File: rtl/pci_target_ctrl.sv
// PCI target bus FSM in front of the 32-bit memory: decodes memory read/write
// cycles, claims them from the memory's address window and paces TRDY#/STOP#.
module pci_target_ctrl #(
    parameter int WAIT_STATES = 0,
    parameter int MAX_BURST   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_n,
    input  logic        irdy_n,
    input  logic [3:0]  cbe_n,
    input  logic [31:0] ad_in,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        devsel_n,
    output logic        trdy_n,
    output logic        stop_n,
    output logic [31:0] mem_add,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_devsel_32,
    input  logic        mem_last_add
);

    typedef enum logic [2:0] {
        IDLE, DECODE, CLAIM, WAIT, XFER, STEP, DISC, TURN
    } state_t;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
    localparam logic [7:0] BURST_LIMIT   = 8'(MAX_BURST);

    state_t      state, state_nxt;
    logic [29:0] addr_q;
    logic        is_read_q;
    logic        last_q;
    logic        frame_q;
    logic [7:0]  beat_q;
    logic [2:0]  wait_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        valid_cmd;
    logic        xfer_edge;

    assign valid_cmd = (cbe_n == CMD_MEM_READ) || (cbe_n == CMD_MEM_WRITE);
    // TRDY# is asserted for the whole of XFER, so IRDY# alone decides the transfer
    assign xfer_edge = (state == XFER) && !irdy_n;

    assign mem_add  = {addr_q, 2'b00};
    assign mem_data = data_q;
    assign mem_be   = be_q;
    assign mem_we   = we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            last_q    <= 1'b0;
            frame_q   <= 1'b0;
            beat_q    <= '0;
            wait_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
        end else begin
            state  <= state_nxt;
            we_q   <= 1'b0;
            wait_q <= (state == WAIT) ? wait_q + 3'd1 : 3'd0;

            if (state == IDLE && state_nxt == DECODE) begin
                addr_q    <= ad_in[31:2];
                is_read_q <= (cbe_n == CMD_MEM_READ);
                beat_q    <= '0;
            end

            // Sampled while the memory shows the beat's own address
            if (state == XFER)
                last_q <= mem_last_add;

            if (xfer_edge) begin
                beat_q  <= beat_q + 8'd1;
                frame_q <= frame_n;
                if (is_read_q) begin
                    if (!mem_last_add)
                        addr_q <= addr_q + 30'd1;
                end else begin
                    data_q <= ad_in;
                    be_q   <= ~cbe_n;
                    we_q   <= 1'b1;
                end
            end

            // Writes advance only after the memory has consumed the current address
            if (we_q && !last_q)
                addr_q <= addr_q + 30'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        devsel_n  = 1'b1;
        trdy_n    = 1'b1;
        stop_n    = 1'b1;
        ad_oe     = 1'b0;
        ad_out    = '0;
        case (state)
            IDLE: begin
                if (!frame_n && valid_cmd)
                    state_nxt = DECODE;
            end
            DECODE: state_nxt = CLAIM;
            CLAIM: begin
                if (mem_devsel_32)
                    state_nxt = IDLE;
                else if (WAIT_STATES == 0)
                    state_nxt = XFER;
                else
                    state_nxt = WAIT;
            end
            WAIT: begin
                devsel_n = 1'b0;
                if (int'(wait_q) >= WAIT_STATES - 1)
                    state_nxt = XFER;
            end
            XFER: begin
                devsel_n = 1'b0;
                trdy_n   = 1'b0;
                if (is_read_q) begin
                    ad_oe  = 1'b1;
                    ad_out = mem_rdata;
                end
                if (!irdy_n)
                    state_nxt = STEP;
            end
            STEP: begin
                devsel_n = 1'b0;
                // A master ending the burst takes priority over a target disconnect
                if (frame_q)
                    state_nxt = TURN;
                else if (last_q || beat_q == BURST_LIMIT)
                    state_nxt = DISC;
                else
                    state_nxt = XFER;
            end
            DISC: begin
                devsel_n = 1'b0;
                stop_n   = 1'b0;
                if (frame_n)
                    state_nxt = TURN;
            end
            TURN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Directed bench for pci_target_ctrl with a small MEM_32 model and a
// scoreboard monitor that checks every write pulse and every read transfer.
module tb_pci_target_ctrl;

    typedef struct packed {
        logic [31:0] add;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        frame_n;
    logic        irdy_n;
    logic [3:0]  cbe_n;
    logic [31:0] ad_in;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic        devsel_n;
    logic        trdy_n;
    logic        stop_n;
    logic [31:0] mem_add;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_devsel_32;
    logic        mem_last_add;

    logic [31:0] mem [0:1023];
    logic [29:0] word_idx;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    wr_t         mon_wr;
    logic [31:0] mon_rd;
    int          checks;
    int          failures;

    localparam logic [104:0] RESET_VEC = {3'b111, 2'b00, 4'h0, 96'h0};

    pci_target_ctrl #(.WAIT_STATES(0), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n),
        .cbe_n(cbe_n), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .devsel_n(devsel_n), .trdy_n(trdy_n), .stop_n(stop_n),
        .mem_add(mem_add), .mem_data(mem_data), .mem_be(mem_be), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_devsel_32(mem_devsel_32), .mem_last_add(mem_last_add)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory window is words 0..0x3FF; End_ADD is word 0x3FF
    assign word_idx      = mem_add[31:2];
    assign mem_devsel_32 = (word_idx > 30'h3FF);
    assign mem_last_add  = (word_idx == 30'h3FF);
    assign mem_rdata     = mem_devsel_32 ? 32'h0 : mem[word_idx[9:0]];

    always @(posedge clk) begin
        if (mem_we && !mem_devsel_32)
            for (int b = 0; b < 4; b++)
                if (mem_be[b])
                    mem[word_idx[9:0]][8*b +: 8] <= mem_data[8*b +: 8];
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: add %0h data %0h", mem_add, mem_data);
            end else begin
                mon_wr = exp_wr.pop_front();
                checkOutput("write", {mem_add, mem_data, mem_be}, mon_wr);
            end
        end
        if (!trdy_n && !irdy_n && ad_oe) begin
            if (exp_rd.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_read: ad_out %0h", ad_out);
            end else begin
                mon_rd = exp_rd.pop_front();
                checkOutput("read", ad_out, mon_rd);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] cmd);
        frame_n = 1'b0;
        irdy_n  = 1'b1;
        ad_in   = addr;
        cbe_n   = cmd;
        @(negedge clk);
    endtask

    // One data phase; done=0 when the target signalled STOP# instead
    task automatic data_beat(input logic [31:0] data, input logic [3:0] be,
                             input logic last, output logic done);
        int n;
        ad_in   = data;
        cbe_n   = be;
        irdy_n  = 1'b0;
        frame_n = last;
        done    = 1'b0;
        n       = 0;
        while (trdy_n && stop_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!trdy_n) begin
            @(negedge clk);
            irdy_n = 1'b1;
            done   = 1'b1;
        end else if (stop_n) begin
            checks++;
            failures++;
            $display("[TB] FAIL beat_timeout: trdy_n %0b, expected 0", trdy_n);
        end
    endtask

    initial begin
        logic done;
        logic seen;
        int   beats;
        int   n;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        frame_n  = 1'b1;
        irdy_n   = 1'b1;
        cbe_n    = 4'hF;
        ad_in    = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h010] = 32'hDEADBEEF;
        mem[10'h3FE] = 32'h11112222;
        mem[10'h3FF] = 32'h33334444;

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    {devsel_n, trdy_n, stop_n, ad_oe, mem_we, mem_be, mem_add, mem_data, ad_out},
                    RESET_VEC);
        rst = 1'b0;
        @(negedge clk);

        // Single read of word 0x10
        exp_rd.push_back(32'hDEADBEEF);
        applyStimulus(32'h40, 4'b0110);
        ad_in = '0; cbe_n = 4'h0; irdy_n = 1'b0; frame_n = 1'b1;
        @(negedge clk);
        checkOutput("t1_devsel_claim", devsel_n, 1'b1);
        @(negedge clk);
        checkOutput("t1_devsel_xfer", devsel_n, 1'b0);
        checkOutput("t1_trdy_xfer", trdy_n, 1'b0);
        checkOutput("t1_ad_drive", {ad_oe, ad_out}, {1'b1, 32'hDEADBEEF});
        @(negedge clk);
        irdy_n = 1'b1;
        checkOutput("t1_trdy_step", trdy_n, 1'b1);
        @(negedge clk);
        checkOutput("t1_turn", {devsel_n, trdy_n, stop_n, ad_oe}, 4'b1110);
        @(negedge clk);

        // Four-beat write burst
        for (int i = 0; i < 4; i++)
            exp_wr.push_back({32'h100 + 32'(4 * i), 32'(i + 1), 4'hF});
        applyStimulus(32'h100, 4'b0111);
        for (int i = 0; i < 4; i++) begin
            data_beat(32'(i + 1), 4'h0, (i == 3), done);
            checkOutput("t2_beat_done", done, 1'b1);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            checkOutput("t2_readback", mem[10'h040 + 10'(i)], 32'(i + 1));

        // Partial byte-enable write
        exp_wr.push_back({32'h200, 32'hAABBCCDD, 4'b0011});
        applyStimulus(32'h200, 4'b0111);
        data_beat(32'hAABBCCDD, 4'b1100, 1'b1, done);
        repeat (3) @(negedge clk);
        checkOutput("t3_mem_be", mem[10'h080], 32'h0000CCDD);

        // Address outside the window is never claimed
        applyStimulus(32'h2000, 4'b0110);
        irdy_n = 1'b0; frame_n = 1'b1; seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (!devsel_n) seen = 1'b1;
        end
        irdy_n = 1'b1;
        checkOutput("t4_no_devsel", seen, 1'b0);

        // Read burst runs into End_ADD and is disconnected
        exp_rd.push_back(32'h11112222);
        exp_rd.push_back(32'h33334444);
        applyStimulus(32'hFF8, 4'b0110);
        data_beat(32'h0, 4'h0, 1'b0, done);
        checkOutput("t5_beat1", done, 1'b1);
        data_beat(32'h0, 4'h0, 1'b0, done);
        checkOutput("t5_beat2", done, 1'b1);
        data_beat(32'h0, 4'h0, 1'b0, done);
        checkOutput("t5_no_beat3", done, 1'b0);
        checkOutput("t5_disc", {stop_n, trdy_n, devsel_n}, 3'b010);
        @(negedge clk);
        checkOutput("t5_disc_hold", {stop_n, trdy_n, devsel_n}, 3'b010);
        frame_n = 1'b1; irdy_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_turn", {stop_n, devsel_n}, 2'b11);
        @(negedge clk);

        // Six-beat write stopped by MAX_BURST=4
        for (int i = 0; i < 4; i++)
            exp_wr.push_back({32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF});
        applyStimulus(32'h300, 4'b0111);
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            data_beat(32'h1000 + 32'(i), 4'h0, 1'b0, done);
            if (!done) break;
            beats++;
        end
        checkOutput("t6_beats", beats, 4);
        checkOutput("t6_disc", {stop_n, trdy_n, devsel_n}, 3'b010);
        frame_n = 1'b1; irdy_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a write burst
        exp_wr.push_back({32'h340, 32'hCAFE0001, 4'hF});
        applyStimulus(32'h340, 4'b0111);
        data_beat(32'hCAFE0001, 4'h0, 1'b0, done);
        ad_in = 32'hCAFE0002; irdy_n = 1'b0;
        n = 0;
        while (trdy_n && n < 10) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t7_reset_outputs",
                    {devsel_n, trdy_n, stop_n, ad_oe, mem_we, mem_be, mem_add, mem_data, ad_out},
                    RESET_VEC);
        rst = 1'b0; frame_n = 1'b1; irdy_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("t7_first_write", mem[10'h0D0], 32'hCAFE0001);
        checkOutput("t7_no_second_write", mem[10'h0D1], 32'h0);

        checkOutput("queues_empty", exp_wr.size() + exp_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
